// File: rtl/game_state_ctrl_pkg.sv
// Shared state codes for the game-flow controller; also consumed by the HUD
// and display_top so the encoding stays in one place.
package game_state_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_INIT     = 3'd0;
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAYING  = 3'd2;
  localparam logic [STATE_W-1:0] ST_HIT      = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAMEOVER = 3'd4;
  localparam logic [STATE_W-1:0] ST_PAUSED   = 3'd5;

  // Codes 6 and 7 fall back here, with the settle timer reloaded.
  localparam logic [STATE_W-1:0] ST_RECOVER  = ST_INIT;

endpackage

// File: rtl/game_state_ctrl_edge_detect_rise.sv
// Rising-edge detector for a level button synchronous to clk; shared by
// other button handlers.
module edge_detect_rise (
  input  logic clk,
  input  logic hard_reset_n,
  input  logic in,
  output logic pe
);

  logic r_in_q;

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      r_in_q <= 1'b0;
    end else begin
      r_in_q <= in;
    end
  end

  assign pe = in & ~r_in_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow controller: settle, start screen, play, invincibility, pause and
// game over, with a saturating heart count and a one-cycle game_reset pulse.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int unsigned MAX_HEARTS    = 3,
  parameter int unsigned HEART_W       = 2,
  parameter int unsigned SETTLE_CYCLES = 20000000,
  parameter int unsigned INVULN_CYCLES = 200000000,
  parameter int unsigned TIMER_W       = 28
) (
  input  logic               clk,
  input  logic               hard_reset_n,
  input  logic               start,
  input  logic               collision,
  input  logic               heart_pickup,
  output logic [HEART_W-1:0] num_hearts,
  output logic [2:0]         game_state,
  output logic               game_en,
  output logic               game_reset
);

  localparam logic [HEART_W-1:0] HEARTS_FULL = HEART_W'(MAX_HEARTS);
  localparam logic [HEART_W-1:0] HEARTS_ONE  = HEART_W'(1);
  localparam logic [TIMER_W-1:0] T_SETTLE    = TIMER_W'(SETTLE_CYCLES);
  localparam logic [TIMER_W-1:0] T_INVULN    = TIMER_W'(INVULN_CYCLES);

  logic [STATE_W-1:0] r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [HEART_W-1:0] r_hearts;
  logic               r_game_en;
  logic               r_game_reset;
  logic               r_resume_hit;

  logic [STATE_W-1:0] w_state_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [HEART_W-1:0] w_hearts_nxt;
  logic               w_game_en_nxt;
  logic               w_game_reset_nxt;
  logic               w_resume_hit_nxt;
  logic               w_start_pe;
  logic               w_timer_zero;
  logic [HEART_W-1:0] w_hearts_inc;

  edge_detect_rise u_start_edge (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .in           (start),
    .pe           (w_start_pe)
  );

  assign w_timer_zero = (r_timer == '0);
  assign w_hearts_inc = (r_hearts < HEARTS_FULL) ? r_hearts + HEART_W'(1) : r_hearts;

  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_hearts_nxt     = r_hearts;
    w_game_en_nxt    = r_game_en;
    w_game_reset_nxt = 1'b0;
    w_resume_hit_nxt = r_resume_hit;

    case (r_state)
      ST_INIT: begin
        if (w_timer_zero) w_state_nxt = ST_IDLE;
        else              w_timer_nxt = r_timer - TIMER_W'(1);
      end
      ST_IDLE: begin
        if (w_start_pe) begin
          w_state_nxt      = ST_PLAYING;
          w_hearts_nxt     = HEARTS_FULL;
          w_game_en_nxt    = 1'b1;
          w_game_reset_nxt = 1'b1;
        end
      end
      ST_PLAYING: begin
        // Collision outranks start and pickup; the losing events are dropped.
        if (collision) begin
          if (r_hearts <= HEARTS_ONE) begin
            w_hearts_nxt  = '0;
            w_game_en_nxt = 1'b0;
            w_state_nxt   = ST_GAMEOVER;
          end else begin
            w_hearts_nxt = r_hearts - HEART_W'(1);
            w_timer_nxt  = T_INVULN;
            w_state_nxt  = ST_HIT;
          end
        end else if (w_start_pe) begin
          w_state_nxt      = ST_PAUSED;
          w_resume_hit_nxt = 1'b0;
          w_game_en_nxt    = 1'b0;
        end else if (heart_pickup) begin
          w_hearts_nxt = w_hearts_inc;
        end
      end
      ST_HIT: begin
        // A pickup lands even when start pauses in the same cycle.
        if (heart_pickup) w_hearts_nxt = w_hearts_inc;
        if (w_start_pe) begin
          w_state_nxt      = ST_PAUSED;
          w_resume_hit_nxt = 1'b1;
          w_game_en_nxt    = 1'b0;
        end else if (w_timer_zero) begin
          w_state_nxt = ST_PLAYING;
        end else begin
          w_timer_nxt = r_timer - TIMER_W'(1);
        end
      end
      ST_GAMEOVER: begin
        if (w_start_pe) begin
          w_hearts_nxt     = HEARTS_FULL;
          w_timer_nxt      = T_SETTLE;
          w_state_nxt      = ST_INIT;
          w_game_reset_nxt = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (w_start_pe) begin
          w_state_nxt   = r_resume_hit ? ST_HIT : ST_PLAYING;
          w_game_en_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_RECOVER;
        w_timer_nxt   = T_SETTLE;
        w_game_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      r_state      <= ST_INIT;
      r_timer      <= T_SETTLE;
      r_hearts     <= HEARTS_FULL;
      r_game_en    <= 1'b0;
      r_game_reset <= 1'b0;
      r_resume_hit <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_hearts     <= w_hearts_nxt;
      r_game_en    <= w_game_en_nxt;
      r_game_reset <= w_game_reset_nxt;
      r_resume_hit <= w_resume_hit_nxt;
    end
  end

  assign num_hearts = r_hearts;
  assign game_state = r_state;
  assign game_en    = r_game_en;
  assign game_reset = r_game_reset;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus randomized play checked
// against a behavioural model of the game rules.
module tb_game_state_ctrl;

  localparam int S    = 4;
  localparam int I    = 3;
  localparam int MAXH = 3;

  logic       clk = 1'b0;
  logic       hard_reset_n = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic       heart_pickup = 1'b0;
  logic [1:0] num_hearts;
  logic [2:0] game_state;
  logic       game_en;
  logic       game_reset;

  int n_checks = 0;
  int n_errors = 0;

  // Model: game phase as output code, remaining countdown, hearts, flags.
  int m_state, m_timer, m_hearts;
  bit m_en, m_rst, m_prev, m_resume;

  game_state_ctrl #(
    .MAX_HEARTS    (MAXH),
    .HEART_W       (2),
    .SETTLE_CYCLES (S),
    .INVULN_CYCLES (I),
    .TIMER_W       (28)
  ) dut (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .start        (start),
    .collision    (collision),
    .heart_pickup (heart_pickup),
    .num_hearts   (num_hearts),
    .game_state   (game_state),
    .game_en      (game_en),
    .game_reset   (game_reset)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic void model_reset();
    m_state = 0; m_timer = S; m_hearts = MAXH;
    m_en = 0; m_rst = 0; m_prev = 0; m_resume = 0;
  endfunction

  function automatic void model_step(bit st, bit col, bit pk);
    bit pe;
    pe = st && !m_prev;
    m_prev = st;
    m_rst = 0;
    case (m_state)
      0: if (m_timer == 0) m_state = 1; else m_timer = m_timer - 1;
      1: if (pe) begin m_state = 2; m_hearts = MAXH; m_en = 1; m_rst = 1; end
      2: begin
        if (col) begin
          if (m_hearts == 1) begin m_hearts = 0; m_en = 0; m_state = 4; end
          else begin m_hearts = m_hearts - 1; m_timer = I; m_state = 3; end
        end else if (pe) begin
          m_state = 5; m_resume = 0; m_en = 0;
        end else if (pk) begin
          m_hearts = (m_hearts + 1 > MAXH) ? MAXH : m_hearts + 1;
        end
      end
      3: begin
        if (pk) m_hearts = (m_hearts + 1 > MAXH) ? MAXH : m_hearts + 1;
        if (pe) begin m_state = 5; m_resume = 1; m_en = 0; end
        else if (m_timer == 0) m_state = 2;
        else m_timer = m_timer - 1;
      end
      4: if (pe) begin m_hearts = MAXH; m_timer = S; m_state = 0; m_rst = 1; end
      5: if (pe) begin m_state = m_resume ? 3 : 2; m_en = 1; end
      default: ;
    endcase
  endfunction

  task automatic tick();
    if (hard_reset_n) model_step(start, collision, heart_pickup);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    hard_reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    hard_reset_n = 1'b1;
    n_checks++;
    if ({game_state, num_hearts, game_en, game_reset} !== {3'd0, 2'd3, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_values: got %h required %h", {game_state, num_hearts, game_en, game_reset}, {3'd0, 2'd3, 1'b0, 1'b0});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({game_state, num_hearts, game_en, game_reset} !== {3'd0, 2'd3, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL init_hold[%0d]: got %h required %h", c, {game_state, num_hearts, game_en, game_reset}, {3'd0, 2'd3, 1'b0, 1'b0});
      end
    end
    tick();
    n_checks++;
    if ({game_state, num_hearts, game_en, game_reset} !== {3'd1, 2'd3, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL init_to_idle: got %h required %h", {game_state, num_hearts, game_en, game_reset}, {3'd1, 2'd3, 1'b0, 1'b0});
    end
  endtask

  task automatic test_start_held();
    int pulses = 0;
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (game_reset) pulses++;
      if (c == 0) begin
        n_checks++;
        if ({game_state, num_hearts, game_en, game_reset} !== {3'd2, 2'd3, 1'b1, 1'b1}) begin
          n_errors++;
          $display("FAIL idle_start: got %h required %h", {game_state, num_hearts, game_en, game_reset}, {3'd2, 2'd3, 1'b1, 1'b1});
        end
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_errors++;
      $display("FAIL reset_pulse_count: got %0d required 1", pulses);
    end
    start = 1'b0;
    tick();
    n_checks++;
    if ({game_state, game_en} !== {3'd2, 1'b1}) begin
      n_errors++;
      $display("FAIL held_no_pause: got %h required %h", {game_state, game_en}, {3'd2, 1'b1});
    end
  endtask

  task automatic test_collisions();
    for (int k = 0; k < 3; k++) begin
      collision = 1'b1;
      tick();
      collision = 1'b0;
      if (k < 2) begin
        int cnt = 1;
        n_checks++;
        if ({game_state, num_hearts, game_en} !== {3'd3, 2'(2 - k), 1'b1}) begin
          n_errors++;
          $display("FAIL hit_entry[%0d]: got %h required %h", k, {game_state, num_hearts, game_en}, {3'd3, 2'(2 - k), 1'b1});
        end
        for (int b = 0; b < 20 && game_state == 3'd3; b++) begin
          if (b == 1) collision = 1'b1;
          tick();
          collision = 1'b0;
          if (game_state == 3'd3) cnt++;
        end
        n_checks++;
        if (cnt !== I + 1) begin
          n_errors++;
          $display("FAIL hit_length[%0d]: got %0d required %0d", k, cnt, I + 1);
        end
        n_checks++;
        if ({game_state, num_hearts} !== {3'd2, 2'(2 - k)}) begin
          n_errors++;
          $display("FAIL hit_ignores_collision[%0d]: got %h required %h", k, {game_state, num_hearts}, {3'd2, 2'(2 - k)});
        end
        repeat (5) tick();
      end else begin
        n_checks++;
        if ({game_state, num_hearts, game_en, game_reset} !== {3'd4, 2'd0, 1'b0, 1'b0}) begin
          n_errors++;
          $display("FAIL gameover: got %h required %h", {game_state, num_hearts, game_en, game_reset}, {3'd4, 2'd0, 1'b0, 1'b0});
        end
      end
    end
  endtask

  task automatic test_gameover_restart();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({game_state, num_hearts, game_en, game_reset} !== {3'd0, 2'd3, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL gameover_restart: got %h required %h", {game_state, num_hearts, game_en, game_reset}, {3'd0, 2'd3, 1'b0, 1'b1});
    end
    tick();
    n_checks++;
    if ({game_state, game_reset} !== {3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL restart_pulse_end: got %h required %h", {game_state, game_reset}, {3'd0, 1'b0});
    end
    for (int b = 0; b < 20 && game_state != 3'd1; b++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({game_state, num_hearts, game_en, game_reset} !== {3'd2, 2'd3, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL replay_start: got %h required %h", {game_state, num_hearts, game_en, game_reset}, {3'd2, 2'd3, 1'b1, 1'b1});
    end
    tick();
  endtask

  task automatic test_pickup();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    for (int b = 0; b < 20 && game_state != 3'd2; b++) tick();
    heart_pickup = 1'b1;
    tick();
    heart_pickup = 1'b0;
    n_checks++;
    if ({game_state, num_hearts} !== {3'd2, 2'd3}) begin
      n_errors++;
      $display("FAIL pickup_inc: got %h required %h", {game_state, num_hearts}, {3'd2, 2'd3});
    end
    heart_pickup = 1'b1;
    tick();
    heart_pickup = 1'b0;
    n_checks++;
    if (num_hearts !== 2'd3) begin
      n_errors++;
      $display("FAIL pickup_saturate: got %0d required 3", num_hearts);
    end
    collision = 1'b1;
    heart_pickup = 1'b1;
    tick();
    collision = 1'b0;
    heart_pickup = 1'b0;
    n_checks++;
    if ({game_state, num_hearts, game_en} !== {3'd3, 2'd2, 1'b1}) begin
      n_errors++;
      $display("FAIL collision_beats_pickup: got %h required %h", {game_state, num_hearts, game_en}, {3'd3, 2'd2, 1'b1});
    end
  endtask

  task automatic test_pause_hit();
    int cnt = 1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({game_state, num_hearts, game_en} !== {3'd5, 2'd2, 1'b0}) begin
      n_errors++;
      $display("FAIL hit_pause: got %h required %h", {game_state, num_hearts, game_en}, {3'd5, 2'd2, 1'b0});
    end
    for (int c = 0; c < 5; c++) begin
      collision = 1'b1;
      tick();
      collision = 1'b0;
      n_checks++;
      if ({game_state, num_hearts, game_en, game_reset} !== {3'd5, 2'd2, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL paused_hold[%0d]: got %h required %h", c, {game_state, num_hearts, game_en, game_reset}, {3'd5, 2'd2, 1'b0, 1'b0});
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({game_state, game_en} !== {3'd3, 1'b1}) begin
      n_errors++;
      $display("FAIL resume_hit: got %h required %h", {game_state, game_en}, {3'd3, 1'b1});
    end
    for (int b = 0; b < 20 && game_state == 3'd3; b++) begin
      tick();
      if (game_state == 3'd3) cnt++;
    end
    n_checks++;
    if (cnt !== 3) begin
      n_errors++;
      $display("FAIL resumed_hit_length: got %0d required 3", cnt);
    end
    n_checks++;
    if (game_state !== 3'd2) begin
      n_errors++;
      $display("FAIL resumed_to_playing: got %0d required 2", game_state);
    end
  endtask

  task automatic test_async_reset();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();
    #2;
    hard_reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({game_state, num_hearts, game_en, game_reset} !== {3'd0, 2'd3, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset: got %h required %h", {game_state, num_hearts, game_en, game_reset}, {3'd0, 2'd3, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1;
    hard_reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) start = ~start;
      collision    = ($urandom_range(0, 7) == 0);
      heart_pickup = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        hard_reset_n = 1'b0;
        model_reset();
        #1;
        @(posedge clk);
        #1;
        hard_reset_n = 1'b1;
      end else begin
        tick();
      end
      n_checks++;
      if ({game_state, num_hearts, game_en, game_reset} !== {3'(m_state), 2'(m_hearts), m_en, m_rst}) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h required %h", c, {game_state, num_hearts, game_en, game_reset}, {3'(m_state), 2'(m_hearts), m_en, m_rst});
      end
    end
    start = 1'b0;
    collision = 1'b0;
    heart_pickup = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_held();
    test_collisions();
    test_gameover_restart();
    test_pickup();
    test_pause_hit();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
